// File: rtl/rv32i_lsu_pkg.sv
// Shared types and constants for the rv32i load/store unit.
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBeat0,
        StBeat1,
        StResp
    } lsu_state_e;

    // funct3[1:0] access-size codes
    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;
    localparam logic [1:0] LSU_D = 2'b11;

    localparam int unsigned LSU_UNSIGNED_BIT = 2;

    function automatic logic [3:0] lsu_nbytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane alignment: two-beat store mask/data and extended load result.
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFFW = $clog2(BYTES)
) (
    input  logic [OFFW-1:0]    off,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    wdata,
    input  logic [2*XLEN-1:0]  hl,
    output logic [2*BYTES-1:0] mask2,
    output logic [2*XLEN-1:0]  wdata2,
    output logic [XLEN-1:0]    rdata_ext
);

    logic [3:0]         nbytes;
    logic [2*BYTES-1:0] ones;
    logic [2*XLEN-1:0]  shifted;
    logic               sign;

    always_comb begin
        nbytes    = lsu_nbytes(funct3[1:0]);
        ones      = '0;
        sign      = 1'b0;
        rdata_ext = '0;
        for (int unsigned i = 0; i < 2 * BYTES; i++) begin
            ones[i] = (i < 32'(nbytes));
        end
        mask2   = ones << off;
        wdata2  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        shifted = hl >> {off, 3'b000};
        case (funct3[1:0])
            LSU_B: sign = shifted[7];
            LSU_H: sign = shifted[15];
            LSU_W: sign = shifted[31];
            LSU_D: sign = shifted[63];
        endcase
        if (funct3[LSU_UNSIGNED_BIT]) begin
            sign = 1'b0;
        end
        // bytes above the access size take the fill value
        for (int unsigned i = 0; i < BYTES; i++) begin
            rdata_ext[8*i +: 8] = (i < 32'(nbytes)) ? shifted[8*i +: 8] : {8{sign}};
        end
    end

endmodule

// File: rtl/rv32i_lsu_unaligned.sv
// RISC-V load/store unit with aligned bus beats; boundary-crossing accesses split into two
// beats when LSU_MISALIGN_EN is defined, otherwise any misaligned access is rejected.
module rv32i_lsu_unaligned
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned BYTES = XLEN / 8,
    localparam int unsigned OFFW = $clog2(BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [BYTES-1:0] mem_wmask,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_err
);

    lsu_state_e      state;
    logic [OFFW-1:0] off_q;
    logic [2:0]      funct3_q;
    logic            we_q;

    logic [OFFW-1:0]    req_off;
    logic [3:0]         req_n;
    logic               req_illegal;
    logic [XLEN-1:0]    base_d;
    logic               go_beat1;
    logic [OFFW-1:0]    al_off;
    logic [2:0]         al_funct3;
    logic [2*XLEN-1:0]  al_hl;
    logic [2*BYTES-1:0] mask2;
    logic [2*XLEN-1:0]  wdata2;
    logic [XLEN-1:0]    rdata_ext;

    assign req_off = req_addr[OFFW-1:0];
    assign req_n   = lsu_nbytes(req_funct3[1:0]);
    assign base_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

`ifdef LSU_MISALIGN_EN
    logic [XLEN-1:0]  base_q;
    logic             split_q;
    logic [BYTES-1:0] mask_hi_q;
    logic [XLEN-1:0]  wdata_hi_q;
    logic [XLEN-1:0]  l_q;
    logic             req_split;

    assign req_split   = (32'(req_off) + 32'(req_n)) > BYTES;
    assign req_illegal = ((req_funct3[1:0] == LSU_D) && (XLEN < 64))
                       || (req_we && req_funct3[LSU_UNSIGNED_BIT])
                       || (req_funct3 == 3'b111);
    assign go_beat1    = (state == StBeat0) && split_q;
    assign al_hl       = (state == StBeat1) ? {mem_rdata, l_q} : {{XLEN{1'b0}}, mem_rdata};
`else
    logic req_misalign;
    logic unused_hi;

    assign req_misalign = (req_off & OFFW'(req_n - 4'd1)) != '0;
    assign req_illegal  = ((req_funct3[1:0] == LSU_D) && (XLEN < 64))
                        || (req_we && req_funct3[LSU_UNSIGNED_BIT])
                        || (req_funct3 == 3'b111)
                        || req_misalign;
    assign go_beat1     = 1'b0;
    assign al_hl        = {{XLEN{1'b0}}, mem_rdata};
    assign unused_hi    = ^{mask2[2*BYTES-1:BYTES], wdata2[2*XLEN-1:XLEN]};
`endif

    // Store positioning uses the incoming request; load assembly uses the latched one.
    assign al_off    = (state == StIdle) ? req_off : off_q;
    assign al_funct3 = (state == StIdle) ? req_funct3 : funct3_q;

    rv32i_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .off       (al_off),
        .funct3    (al_funct3),
        .wdata     (req_wdata),
        .hl        (al_hl),
        .mask2     (mask2),
        .wdata2    (wdata2),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            off_q     <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
`ifdef LSU_MISALIGN_EN
            base_q     <= '0;
            split_q    <= 1'b0;
            mask_hi_q  <= '0;
            wdata_hi_q <= '0;
            l_q        <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_q     <= req_off;
                        funct3_q  <= req_funct3;
                        we_q      <= req_we;
`ifdef LSU_MISALIGN_EN
                        base_q     <= base_d;
                        split_q    <= req_split;
                        mask_hi_q  <= req_we ? mask2[2*BYTES-1:BYTES] : '0;
                        wdata_hi_q <= req_we ? wdata2[2*XLEN-1:XLEN] : '0;
`endif
                        if (req_illegal) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= StBeat0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= base_d;
                            mem_wmask <= req_we ? mask2[BYTES-1:0] : '0;
                            mem_wdata <= req_we ? wdata2[XLEN-1:0] : '0;
                        end
                    end
                end
                StBeat0, StBeat1: begin
                    if (mem_ack) begin
                        if (go_beat1) begin
`ifdef LSU_MISALIGN_EN
                            state     <= StBeat1;
                            mem_addr  <= base_q + XLEN'(BYTES);
                            mem_wmask <= mask_hi_q;
                            mem_wdata <= wdata_hi_q;
                            l_q       <= mem_rdata;
`endif
                        end else begin
                            state     <= StResp;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wmask <= '0;
                            mem_wdata <= '0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= we_q ? '0 : rdata_ext;
                        end
                    end
                end
                StResp: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
